// File: rtl/pwm_breath_multi_pkg.sv
// Shared types and helpers for the multi-channel breathing PWM block.
// Mode encodings match the 2-bit per-channel fields of the mode input.
package pwm_breath_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF         = 2'd0;
  localparam mode_t MODE_ON          = 2'd1;
  localparam mode_t MODE_BREATHE     = 2'd2;
  localparam mode_t MODE_BREATHE_INV = 2'd3;

  // Counter width able to hold 0..max_val-1; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/pwm_breath_multi_tick_div.sv
// Prescaler plus PWM step counter. Both hold while en is low.
// pend marks the final step tick of each PWM period.
module tick_div
  import pwm_breath_pkg::*;
#(
  parameter int CLK_DIV   = 24,
  parameter int PWM_STEPS = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  output logic                          pend,
  output logic [cnt_w(PWM_STEPS)-1:0]   pwm_cnt
);

  localparam int PW = cnt_w(CLK_DIV);
  localparam int CW = cnt_w(PWM_STEPS);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_STEPS - 1);

  logic [PW-1:0] presc;
  logic          tick;

  // With CLK_DIV=1 presc is pinned at 0, so every enabled cycle ticks.
  assign tick = en && (presc == PRE_LAST);
  assign pend = tick && (pwm_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (en) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
      if (tick)
        pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_breath_multi.sv
// Multi-channel breathing-LED PWM: one shared triangle level, per-channel
// mode shadowed at period boundaries so a mode change never cuts a period.
module pwm_breath_multi
  import pwm_breath_pkg::*;
#(
  parameter int CLK_DIV    = 24,
  parameter int PWM_STEPS  = 1000,
  parameter int N_CH       = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [2*N_CH-1:0]             mode,
  output logic [N_CH-1:0]               led_out,
  output logic [cnt_w(PWM_STEPS)-1:0]   level,
  output logic                          period_end,
  output logic                          breath_end
);

  localparam int LW = cnt_w(PWM_STEPS);
  localparam logic [LW-1:0] LMAX = LW'(PWM_STEPS - 1);
  localparam logic [N_CH-1:0] INACTIVE = {N_CH{ACTIVE_LOW}};

  logic               pend;
  logic [LW-1:0]      pwm_cnt;
  logic [LW-1:0]      level_nxt;
  logic               dir_down, dir_nxt;
  mode_t [N_CH-1:0]   mode_sh;
  logic [N_CH-1:0]    raw;

  tick_div #(
    .CLK_DIV   (CLK_DIV),
    .PWM_STEPS (PWM_STEPS)
  ) u_tick_div (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pend    (pend),
    .pwm_cnt (pwm_cnt)
  );

  // Triangle walk; the turnaround skips repeating the end value.
  always_comb begin
    level_nxt = level;
    dir_nxt   = dir_down;
    if (!dir_down) begin
      if (level == LMAX) begin
        dir_nxt   = 1'b1;
        level_nxt = LMAX - 1'b1;
      end else begin
        level_nxt = level + 1'b1;
      end
    end else begin
      if (level == '0) begin
        dir_nxt   = 1'b0;
        level_nxt = LW'(1);
      end else begin
        level_nxt = level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level      <= '0;
      dir_down   <= 1'b0;
      mode_sh    <= '0;
      period_end <= 1'b0;
      breath_end <= 1'b0;
    end else begin
      period_end <= pend;
      breath_end <= pend && (level_nxt == '0);
      if (pend) begin
        level    <= level_nxt;
        dir_down <= dir_nxt;
        mode_sh  <= mode;
      end
    end
  end

  // ON is the full-duty case; the others compare against a duty below full.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign raw[i] = (mode_sh[i] == MODE_ON) ||
                    ((mode_sh[i] == MODE_BREATHE)     && (pwm_cnt < level)) ||
                    ((mode_sh[i] == MODE_BREATHE_INV) && (pwm_cnt < (LMAX - level)));
  end

  always_ff @(posedge clk) begin
    if (rst)
      led_out <= INACTIVE;
    else if (en)
      led_out <= raw ^ INACTIVE;
    else
      led_out <= INACTIVE;
  end

endmodule

// File: tb/tb_pwm_breath_multi.sv
// Directed bench: base config, an ACTIVE_LOW copy and a CLK_DIV=1 copy
// all driven by the same stimulus (PWM_STEPS=4, N_CH=2).
module tb_pwm_breath_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] mode = 4'b0000;

  logic [1:0] led_b, led_a, led_c;
  logic [1:0] lvl_b, lvl_a, lvl_c;
  logic       pe_b, pe_a, pe_c;
  logic       be_b, be_a, be_c;

  int n;
  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  pwm_breath_multi #(.CLK_DIV(2), .PWM_STEPS(4), .N_CH(2), .ACTIVE_LOW(1'b0)) u_base (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .led_out(led_b), .level(lvl_b), .period_end(pe_b), .breath_end(be_b));

  pwm_breath_multi #(.CLK_DIV(2), .PWM_STEPS(4), .N_CH(2), .ACTIVE_LOW(1'b1)) u_al (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .led_out(led_a), .level(lvl_a), .period_end(pe_a), .breath_end(be_a));

  pwm_breath_multi #(.CLK_DIV(1), .PWM_STEPS(4), .N_CH(2), .ACTIVE_LOW(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .led_out(led_c), .level(lvl_c), .period_end(pe_c), .breath_end(be_c));

  // Triangle 0,1,2,3,2,1,0,... indexed by completed PWM periods.
  function automatic int seq_lvl(input int k);
    int p;
    p = k % 6;
    return (p <= 3) ? p : 6 - p;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic do_reset(input logic [3:0] m);
    rst = 1'b1; en = 1'b1; mode = m;
    step; step;
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; mode = 4'b0000;
    step; step;
    total++; if ({lvl_b, pe_b, be_b, led_b} !== 6'b00_0_0_00)
      $display("FAIL reset_base got=%b want=%b", {lvl_b, pe_b, be_b, led_b}, 6'b00_0_0_00); else pass_cnt++;
    total++; if ({lvl_a, pe_a, be_a, led_a} !== 6'b00_0_0_11)
      $display("FAIL reset_al got=%b want=%b", {lvl_a, pe_a, be_a, led_a}, 6'b00_0_0_11); else pass_cnt++;
    total++; if ({lvl_c, pe_c, be_c, led_c} !== 6'b00_0_0_00)
      $display("FAIL reset_c1 got=%b want=%b", {lvl_c, pe_c, be_c, led_c}, 6'b00_0_0_00); else pass_cnt++;
  endtask

  task automatic test_breathe;
    int pm;
    logic eb, ec;
    logic [5:0] exp_b, exp_a, exp_c;
    do_reset(4'b1010);
    repeat (100) begin
      step;
      pm = n - 1;
      eb = (pm >= 8) && (((pm / 2) % 4) < seq_lvl(pm / 8));
      ec = (pm >= 4) && ((pm % 4) < seq_lvl(pm / 4));
      exp_b = {2'(seq_lvl(n / 8)), 1'(n % 8 == 0), 1'(n % 48 == 0), eb, eb};
      exp_a = {exp_b[5:2], ~eb, ~eb};
      exp_c = {2'(seq_lvl(n / 4)), 1'(n % 4 == 0), 1'(n % 24 == 0), ec, ec};
      total++; if ({lvl_b, pe_b, be_b, led_b} !== exp_b)
        $display("FAIL breathe_base n=%0d got=%b want=%b", n, {lvl_b, pe_b, be_b, led_b}, exp_b); else pass_cnt++;
      total++; if ({lvl_a, pe_a, be_a, led_a} !== exp_a)
        $display("FAIL breathe_al n=%0d got=%b want=%b", n, {lvl_a, pe_a, be_a, led_a}, exp_a); else pass_cnt++;
      total++; if ({lvl_c, pe_c, be_c, led_c} !== exp_c)
        $display("FAIL breathe_c1 n=%0d got=%b want=%b", n, {lvl_c, pe_c, be_c, led_c}, exp_c); else pass_cnt++;
    end
  endtask

  task automatic test_duty;
    int hi0 [7];
    int hi1 [7];
    int k;
    for (int i = 0; i < 7; i++) begin hi0[i] = 0; hi1[i] = 0; end
    do_reset(4'b1110);
    repeat (56) begin
      step;
      k = (n - 1) / 8;
      hi0[k] += int'(led_b[0]);
      hi1[k] += int'(led_b[1]);
    end
    total++; if (hi0[1] !== 2) $display("FAIL duty_l1_ch0 got=%0d want=2", hi0[1]); else pass_cnt++;
    total++; if (hi1[1] !== 4) $display("FAIL duty_l1_ch1 got=%0d want=4", hi1[1]); else pass_cnt++;
    total++; if (hi0[2] !== 4) $display("FAIL duty_l2_ch0 got=%0d want=4", hi0[2]); else pass_cnt++;
    total++; if (hi1[2] !== 2) $display("FAIL duty_l2_ch1 got=%0d want=2", hi1[2]); else pass_cnt++;
    total++; if (hi0[3] !== 6) $display("FAIL duty_l3_ch0 got=%0d want=6", hi0[3]); else pass_cnt++;
    total++; if (hi1[3] !== 0) $display("FAIL duty_l3_ch1 got=%0d want=0", hi1[3]); else pass_cnt++;
  endtask

  task automatic test_on_off;
    int bad;
    do_reset(4'b0001);
    repeat (8) step;
    total++; if (led_b !== 2'b00) $display("FAIL onoff_pre got=%b want=00", led_b); else pass_cnt++;
    bad = 0;
    repeat (100) begin
      step;
      if (led_b !== 2'b01 || led_a !== 2'b10 || led_c !== 2'b01) bad++;
    end
    total++; if (bad !== 0) $display("FAIL onoff_const bad_cycles=%0d want=0", bad); else pass_cnt++;
  endtask

  task automatic test_mode_change;
    int bad;
    do_reset(4'b0000);
    repeat (10) step;
    mode = 4'b0101;
    bad = 0;
    repeat (6) begin
      step;
      if (led_b !== 2'b00) bad++;
    end
    total++; if (bad !== 0) $display("FAIL modechg_hold bad_cycles=%0d want=0", bad); else pass_cnt++;
    step;
    total++; if (led_b !== 2'b11) $display("FAIL modechg_on got=%b want=11", led_b); else pass_cnt++;
  endtask

  task automatic test_pause;
    int bad;
    do_reset(4'b1010);
    repeat (20) step;
    total++; if ({lvl_b, led_b} !== 4'b10_11)
      $display("FAIL pause_pre got=%b want=1011", {lvl_b, led_b}); else pass_cnt++;
    en = 1'b0;
    bad = 0;
    repeat (20) begin
      step;
      if (led_b !== 2'b00 || led_a !== 2'b11 || lvl_b !== 2'd2 || pe_b !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL pause_hold bad_cycles=%0d want=0", bad); else pass_cnt++;
    en = 1'b1;
    repeat (3) step;
    total++; if ({lvl_b, pe_b} !== 3'b10_0)
      $display("FAIL pause_resume_pre got=%b want=100", {lvl_b, pe_b}); else pass_cnt++;
    step;
    total++; if ({lvl_b, pe_b} !== 3'b11_1)
      $display("FAIL pause_resume_pend got=%b want=111", {lvl_b, pe_b}); else pass_cnt++;
  endtask

  task automatic test_rst_mid;
    do_reset(4'b1010);
    repeat (28) step;
    total++; if ({lvl_b, led_b} !== 4'b11_11)
      $display("FAIL rstmid_pre got=%b want=1111", {lvl_b, led_b}); else pass_cnt++;
    rst = 1'b1;
    step;
    total++; if ({lvl_b, pe_b, led_b, led_a} !== 7'b00_0_00_11)
      $display("FAIL rstmid_clear got=%b want=0000011", {lvl_b, pe_b, led_b, led_a}); else pass_cnt++;
    rst = 1'b0;
    n = 0;
    repeat (7) step;
    total++; if (pe_b !== 1'b0) $display("FAIL rstmid_early_pend got=%b want=0", pe_b); else pass_cnt++;
    step;
    total++; if ({lvl_b, pe_b} !== 3'b01_1)
      $display("FAIL rstmid_first_pend got=%b want=011", {lvl_b, pe_b}); else pass_cnt++;
  endtask

  initial begin
    n = 0;
    test_reset;
    test_breathe;
    test_duty;
    test_on_off;
    test_mode_change;
    test_pause;
    test_rst_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
